// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
// Imported by fetch_ctrl and fetch_timeout_cnt.
package fetch_ctrl_pkg;

   localparam int unsigned TimeoutCyclesDefault = 16;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StFetch = 3'd1,
      StExec  = 3'd2,
      StHalt  = 3'd3,
      StFault = 3'd4
   } state_e;

   typedef logic [31:0] perf_cnt_t;

endpackage

// File: rtl/fetch_timeout_cnt.sv
// Fetch wait counter: counts FETCH cycles without imem_ready and flags the last allowed cycle.
module fetch_timeout_cnt
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned Limit = TimeoutCyclesDefault
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int unsigned W = (Limit > 1) ? $clog2(Limit) : 1;
   localparam logic [W-1:0] Last = W'(Limit - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == Last);

endmodule

// File: rtl/fetch_ctrl.sv
// Multi-cycle fetch/commit sequencer for the RV32I PC unit.
// Optional perf counters (cycle_cnt, instret_cnt) are enabled by FETCH_PERF_CNT_EN.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
   input  logic      clk,
   input  logic      areset,
   input  logic      start,
   input  logic      imem_ready,
   input  logic      stall,
   input  logic      halt_req,
   input  logic      branch_taken,
   output logic      imem_req,
   output logic      pc_load,
   output logic      pc_src,
   output logic      instr_valid,
   output logic      busy,
   output logic      halted,
   output logic      fault
`ifdef FETCH_PERF_CNT_EN
   ,
   output perf_cnt_t cycle_cnt,
   output perf_cnt_t instret_cnt
`endif
);

   state_e state_q, state_d;
   logic   expired;
   logic   cnt_clr;
   logic   cnt_inc;

   // Counter only runs inside FETCH, so it is zero on every FETCH entry.
   assign cnt_clr = (state_q != StFetch);
   assign cnt_inc = (state_q == StFetch) && !imem_ready && !expired;

   fetch_timeout_cnt #(
      .Limit (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk),
      .rst_i     (areset),
      .clr_i     (cnt_clr),
      .inc_i     (cnt_inc),
      .expired_o (expired)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start) state_d = StFetch;
         StFetch: begin
            if (imem_ready) begin
               state_d = StExec;
            end else if (expired) begin
               state_d = StFault;
            end
         end
         StExec: begin
            if (halt_req) begin
               state_d = StHalt;
            end else if (!stall) begin
               state_d = StFetch;
            end
         end
         StHalt:  state_d = StHalt;
         StFault: state_d = StFault;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   assign imem_req    = (state_q == StFetch) && !areset;
   assign pc_load     = (state_q == StExec) && !halt_req && !stall && !areset;
   assign pc_src      = pc_load && branch_taken;
   assign instr_valid = (state_q == StExec);
   assign busy        = (state_q == StFetch) || (state_q == StExec);
   assign halted      = (state_q == StHalt);
   assign fault       = (state_q == StFault);

`ifdef FETCH_PERF_CNT_EN
   perf_cnt_t cycle_cnt_q, instret_cnt_q;

   always_ff @(posedge clk) begin
      if (areset) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
      end else begin
         if (busy)    cycle_cnt_q   <= cycle_cnt_q + 32'd1;
         if (pc_load) instret_cnt_q <= instret_cnt_q + 32'd1;
      end
   end

   assign cycle_cnt   = cycle_cnt_q;
   assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the driver queues the expected output vector for each
// cycle it drives, and a negedge monitor pops and compares.
module tb_fetch_ctrl;

   logic clk = 1'b0;
   logic areset, start, imem_ready, stall, halt_req, branch_taken;
   logic imem_req, pc_load, pc_src, instr_valid, busy, halted, fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cycle_cnt, instret_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Output vector order: {imem_req, pc_load, pc_src, instr_valid, busy, halted, fault}
   localparam logic [6:0] E_IDLE    = 7'b0000000;
   localparam logic [6:0] E_FETCH   = 7'b1000100;
   localparam logic [6:0] E_FETCHR  = 7'b0000100;
   localparam logic [6:0] E_EXHOLD  = 7'b0001100;
   localparam logic [6:0] E_EXLOAD  = 7'b0101100;
   localparam logic [6:0] E_EXBR    = 7'b0111100;
   localparam logic [6:0] E_HALT    = 7'b0000010;
   localparam logic [6:0] E_FAULT   = 7'b0000001;

   typedef struct {
      logic [6:0] exp;
      string      name;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   fetch_ctrl #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .areset       (areset),
      .start        (start),
      .imem_ready   (imem_ready),
      .stall        (stall),
      .halt_req     (halt_req),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .pc_load      (pc_load),
      .pc_src       (pc_src),
      .instr_valid  (instr_valid),
      .busy         (busy),
      .halted       (halted),
      .fault        (fault)
`ifdef FETCH_PERF_CNT_EN
      ,
      .cycle_cnt    (cycle_cnt),
      .instret_cnt  (instret_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: outputs are combinational, so sample mid-cycle once inputs have settled.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         chk(e.name, {25'd0, imem_req, pc_load, pc_src, instr_valid, busy, halted, fault},
             {25'd0, e.exp});
      end
   end

   task automatic step(input logic rst, input logic st, input logic rdy, input logic stl,
                       input logic hlt, input logic br, input logic [6:0] exp,
                       input string name);
      exp_t e;
      @(posedge clk);
      #1;
      areset       = rst;
      start        = st;
      imem_ready   = rdy;
      stall        = stl;
      halt_req     = hlt;
      branch_taken = br;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
   endtask

   initial begin
      areset = 1'b1; start = 1'b0; imem_ready = 1'b0;
      stall = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;

      // Reset and idle
      step(1, 0, 0, 0, 0, 0, E_IDLE, "reset_idle");
      step(0, 0, 0, 0, 0, 0, E_IDLE, "post_reset");

      // Back-to-back fetch/exec with start held high
      step(0, 1, 1, 0, 0, 0, E_IDLE, "idle_start");
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 0, 0, 0, E_FETCH, "seq_fetch");
         step(0, 1, 1, 0, 0, 0, E_EXLOAD, "seq_exec");
      end

      // Stall three cycles, then commit a taken branch
      step(0, 0, 1, 0, 0, 0, E_FETCH, "stall_fetch");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 1, E_EXHOLD, "stall_hold");
      step(0, 0, 0, 0, 0, 1, E_EXBR, "stall_release_br");

      // Timeout: 16 FETCH cycles without ready
      for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, E_FETCH, "to_fetch");
      step(0, 1, 0, 0, 0, 0, E_FAULT, "to_fault");
      step(0, 1, 1, 0, 0, 0, E_FAULT, "fault_sticky");
      step(1, 0, 0, 0, 0, 0, E_FAULT, "fault_in_reset");
      step(0, 0, 0, 0, 0, 0, E_IDLE, "fault_cleared");

      // Ready on the 16th FETCH cycle wins over timeout; then halt beats stall
      step(0, 1, 0, 0, 0, 0, E_IDLE, "edge_start");
      for (int i = 0; i < 15; i++) step(0, 0, 0, 0, 0, 0, E_FETCH, "edge_fetch");
      step(0, 0, 1, 0, 0, 0, E_FETCH, "edge_ready16");
      step(0, 0, 0, 1, 1, 1, E_EXHOLD, "halt_and_stall");
      step(0, 1, 1, 0, 0, 0, E_HALT, "halted");
      step(0, 1, 1, 0, 0, 0, E_HALT, "halt_sticky");
      step(1, 0, 0, 0, 0, 0, E_HALT, "halt_in_reset");
      step(0, 0, 0, 0, 0, 0, E_IDLE, "halt_cleared");

      // Reset forcing of imem_req in FETCH and pc_load in EXEC
      step(0, 1, 0, 0, 0, 0, E_IDLE, "rf_start");
      step(1, 0, 0, 0, 0, 0, E_FETCHR, "reset_in_fetch");
      step(0, 1, 1, 0, 0, 0, E_IDLE, "rf_idle");
      step(0, 0, 1, 0, 0, 0, E_FETCH, "rf_fetch");
      step(1, 0, 0, 0, 0, 1, E_EXHOLD, "reset_in_exec");
      step(0, 0, 0, 0, 0, 0, E_IDLE, "re_idle");

`ifdef FETCH_PERF_CNT_EN
      step(1, 0, 0, 0, 0, 0, E_IDLE, "perf_reset");
      step(0, 1, 1, 0, 0, 0, E_IDLE, "perf_start");
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 0, 0, 0, E_FETCH, "perf_fetch");
         step(0, 0, 1, 0, 0, 0, E_EXLOAD, "perf_exec");
      end
      step(0, 0, 1, 0, 0, 0, E_FETCH, "perf_fetch11");
      chk("cycle_cnt_20", cycle_cnt, 32'd20);
      chk("instret_cnt_10", instret_cnt, 32'd10);
      step(0, 0, 0, 0, 1, 0, E_EXHOLD, "perf_halt");
      step(0, 0, 0, 0, 0, 0, E_HALT, "perf_halted");
      step(0, 0, 0, 0, 0, 0, E_HALT, "perf_halted2");
      chk("cycle_cnt_hold", cycle_cnt, 32'd22);
      chk("instret_cnt_hold", instret_cnt, 32'd10);
`endif

      // Bounded drain of the scoreboard
      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
